// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: FSM state encoding and a constant clog2.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One combinational restoring square-root step: appends a radicand bit pair to the
// partial remainder and tries to subtract 4*root+1.
module sqrt_step #(
  parameter int QW = 16
) (
  input  logic [QW-1:0] rem,
  input  logic [1:0]    pair,
  input  logic [QW-1:0] root,
  output logic [QW:0]   rem_next,
  output logic          root_bit
);

  logic [QW+1:0] shifted;
  logic [QW+1:0] trial;

  assign shifted  = {rem, pair};
  assign trial    = shifted - {root, 2'b01};
  // A borrow out of the trial subtraction means the new root bit is 0 and we restore.
  assign root_bit = ~trial[QW+1];
  assign rem_next = root_bit ? trial[QW:0] : shifted[QW:0];

endmodule

// File: rtl/sqrt_restoring_pipe.sv
// Multi-cycle restoring integer square root with valid/ready handshakes, BPC root
// bits per clock. Optional round-to-nearest root output under `define SQRT_ROUND_EN.
module sqrt_restoring_pipe
  import arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   d,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH/2-1:0] q,
  output logic [WIDTH/2:0]   r,
  output logic               busy
);

  localparam int QW    = WIDTH / 2;
  localparam int RW    = WIDTH / 2 + 1;
  localparam int STEPS = WIDTH / (2 * BPC);
  localparam int CW    = (clog2(STEPS) < 1) ? 1 : clog2(STEPS);

  state_t           state;
  logic [WIDTH-1:0] dd;
  logic [QW-1:0]    rem;
  logic [QW-1:0]    root;
  logic [CW-1:0]    cnt;

  // Step chain: index k holds the operands entering step k of this cycle.
  logic [QW-1:0] rem_c  [0:BPC];
  logic [QW-1:0] root_c [0:BPC];
  logic [RW-1:0] rem_n  [0:BPC-1];

  assign rem_c[0]  = rem;
  assign root_c[0] = root;

  for (genvar k = 0; k < BPC; k++) begin : g_step
    logic root_bit;

    sqrt_step #(.QW(QW)) u_step (
      .rem      (rem_c[k]),
      .pair     (dd[WIDTH-1-2*k -: 2]),
      .root     (root_c[k]),
      .rem_next (rem_n[k]),
      .root_bit (root_bit)
    );

    assign rem_c[k+1]  = rem_n[k][QW-1:0];
    assign root_c[k+1] = {root_c[k][QW-2:0], root_bit};
  end

  logic [QW-1:0] q_final;
  logic          last;

`ifdef SQRT_ROUND_EN
  // Round up when the remainder exceeds the floor root, i.e. d >= (q+0.5)^2 exceeded.
  assign q_final = ((rem_n[BPC-1] > {1'b0, root_c[BPC]}) && !(&root_c[BPC]))
                   ? root_c[BPC] + 1'b1 : root_c[BPC];
`else
  assign q_final = root_c[BPC];
`endif

  assign last = (cnt == CW'(STEPS - 1));

  always_ff @(posedge clk or negedge clrn) begin
    // NOTE: the async reset clears the whole datapath, not just the FSM, so an
    // aborted computation leaves no stale root/remainder visible on q/r.
    if (!clrn) begin
      state <= IDLE;
      dd    <= '0;
      rem   <= '0;
      root  <= '0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here sees the
      // pre-edge value of the others regardless of statement order.
      case (state)
        IDLE: begin
          if (in_valid) begin
            dd    <= d;
            rem   <= '0;
            root  <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          dd   <= dd << (2 * BPC);
          rem  <= rem_c[BPC];
          root <= root_c[BPC];
          cnt  <= cnt + 1'b1;
          if (last) begin
            q     <= q_final;
            r     <= rem_n[BPC-1];
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == CALC);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_sqrt_restoring_pipe.sv
// Directed bench for sqrt_restoring_pipe: one BPC=1 and one BPC=2 instance, WIDTH=32.
// Expected roots follow the SQRT_ROUND_EN define used for the build.
module tb_sqrt_restoring_pipe;

`ifdef SQRT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  logic        iv_a, ir_a, ov_a, ordy_a, busy_a;
  logic [31:0] d_a;
  logic [15:0] q_a;
  logic [16:0] r_a;
  logic        iv_b, ir_b, ov_b, ordy_b, busy_b;
  logic [31:0] d_b;
  logic [15:0] q_b;
  logic [16:0] r_b;

  sqrt_restoring_pipe #(.WIDTH(32), .BPC(1)) dut_a (
    .clk(clk), .clrn(clrn), .in_valid(iv_a), .in_ready(ir_a), .d(d_a),
    .out_valid(ov_a), .out_ready(ordy_a), .q(q_a), .r(r_a), .busy(busy_a)
  );

  sqrt_restoring_pipe #(.WIDTH(32), .BPC(2)) dut_b (
    .clk(clk), .clrn(clrn), .in_valid(iv_b), .in_ready(ir_b), .d(d_b),
    .out_valid(ov_b), .out_ready(ordy_b), .q(q_b), .r(r_b), .busy(busy_b)
  );

  int cmp = 0;
  int bad = 0;
  int sel = 0;

  logic        v_ir, v_ov, v_busy;
  logic [15:0] v_q;
  logic [16:0] v_r;

  always_comb begin
    if (sel == 0) begin
      v_ir = ir_a; v_ov = ov_a; v_busy = busy_a; v_q = q_a; v_r = r_a;
    end else begin
      v_ir = ir_b; v_ov = ov_b; v_busy = busy_b; v_q = q_b; v_r = r_b;
    end
  end

  task automatic drive(input logic v, input logic [31:0] dv, input logic o);
    if (sel == 0) begin
      iv_a = v; d_a = dv; ordy_a = o;
    end else begin
      iv_b = v; d_b = dv; ordy_b = o;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transaction from IDLE: offer, count latency, check result, hand over.
  task automatic run_op(input string name, input logic [31:0] dv,
                        input logic [15:0] eq, input logic [16:0] er, input int lat);
    int n;
    cmp++;
    if (v_ir !== 1'b1) begin
      bad++; $display("FAIL %s idle in_ready: got %b want 1 (dut %0d)", name, v_ir, sel);
    end
    drive(1'b1, dv, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    cmp++;
    if (v_busy !== 1'b1) begin
      bad++; $display("FAIL %s accept busy: got %b want 1 (dut %0d)", name, v_busy, sel);
    end
    n = 0;
    while (v_ov !== 1'b1 && n < lat + 4) begin
      tick();
      n++;
    end
    cmp++;
    if (n != lat) begin
      bad++; $display("FAIL %s latency: got %0d want %0d (dut %0d)", name, n, lat, sel);
    end
    cmp++;
    if (v_q !== eq) begin
      bad++; $display("FAIL %s q: got %h want %h (dut %0d)", name, v_q, eq, sel);
    end
    cmp++;
    if (v_r !== er) begin
      bad++; $display("FAIL %s r: got %h want %h (dut %0d)", name, v_r, er, sel);
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    cmp++;
    if (v_ov !== 1'b0 || v_ir !== 1'b1) begin
      bad++; $display("FAIL %s handshake: out_valid=%b in_ready=%b want 0/1 (dut %0d)",
                      name, v_ov, v_ir, sel);
    end
  endtask

  task automatic test_reset;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      cmp++;
      if (v_ov !== 1'b0 || v_busy !== 1'b0 || v_ir !== 1'b1) begin
        bad++; $display("FAIL reset flags: ov=%b busy=%b ir=%b want 0/0/1 (dut %0d)",
                        v_ov, v_busy, v_ir, s);
      end
      cmp++;
      if (v_q !== 16'h0 || v_r !== 17'h0) begin
        bad++; $display("FAIL reset q/r: got %h/%h want 0/0 (dut %0d)", v_q, v_r, s);
      end
    end
  endtask

  task automatic test_sweep(input int s, input int lat);
    logic [31:0] tv_d [6];
    logic [15:0] tv_q [6];
    logic [15:0] tv_qr[6];
    logic [16:0] tv_r [6];
    tv_d = '{32'd0, 32'hFFFF_FFFF, 32'd2, 32'd99, 32'd1000000, 32'h4000_0000};
    tv_q = '{16'd0, 16'hFFFF, 16'd1, 16'd9, 16'd1000, 16'h8000};
    tv_qr = '{16'd0, 16'hFFFF, 16'd1, 16'd10, 16'd1000, 16'h8000};
    tv_r = '{17'd0, 17'h1FFFE, 17'd1, 17'd18, 17'd0, 17'd0};
    sel = s;
    #1;
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("sweep_d%0d", i), tv_d[i], RND ? tv_qr[i] : tv_q[i], tv_r[i], lat);
    end
  endtask

  task automatic test_backpressure;
    int n;
    logic [15:0] eq;
    sel = 0;
    #1;
    eq = RND ? 16'd10 : 16'd9;
    drive(1'b1, 32'd99, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    n = 0;
    while (v_ov !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    cmp++;
    if (n != 16) begin
      bad++; $display("FAIL bp latency: got %0d want 16", n);
    end
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 32'd1000000, 1'b0);
      tick();
      cmp++;
      if (v_ov !== 1'b1 || v_ir !== 1'b0 || v_q !== eq || v_r !== 17'd18) begin
        bad++; $display("FAIL bp hold c%0d: ov=%b ir=%b q=%h r=%h want 1/0/%h/12",
                        c, v_ov, v_ir, v_q, v_r, eq);
      end
    end
    drive(1'b1, 32'd1000000, 1'b1);
    tick();
    cmp++;
    if (v_ov !== 1'b0 || v_ir !== 1'b1 || v_busy !== 1'b0) begin
      bad++; $display("FAIL bp release: ov=%b ir=%b busy=%b want 0/1/0", v_ov, v_ir, v_busy);
    end
    drive(1'b1, 32'd1000000, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    cmp++;
    if (v_busy !== 1'b1) begin
      bad++; $display("FAIL bp second accept: busy=%b want 1", v_busy);
    end
    n = 0;
    while (v_ov !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    cmp++;
    if (n != 16 || v_q !== 16'd1000 || v_r !== 17'd0) begin
      bad++; $display("FAIL bp second result: lat=%0d q=%h r=%h want 16/3e8/0", n, v_q, v_r);
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid;
    sel = 0;
    #1;
    drive(1'b1, 32'hFFFF_FFFF, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    repeat (5) tick();
    clrn = 1'b0;
    #1;
    cmp++;
    if (v_ov !== 1'b0 || v_busy !== 1'b0 || v_ir !== 1'b1) begin
      bad++; $display("FAIL midreset flags: ov=%b busy=%b ir=%b want 0/0/1", v_ov, v_busy, v_ir);
    end
    cmp++;
    if (v_q !== 16'h0 || v_r !== 17'h0) begin
      bad++; $display("FAIL midreset q/r: got %h/%h want 0/0", v_q, v_r);
    end
    @(negedge clk);
    clrn = 1'b1;
    tick();
    run_op("after_reset_d91", 32'd91, RND ? 16'd10 : 16'd9, 17'd10, 16);
    run_op("after_reset_d90", 32'd90, 16'd9, 17'd9, 16);
  endtask

  initial begin
    clrn = 1'b0;
    iv_a = 1'b0; d_a = '0; ordy_a = 1'b0;
    iv_b = 1'b0; d_b = '0; ordy_b = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    clrn = 1'b1;
    tick();
    test_sweep(0, 16);
    test_sweep(1, 8);
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
